// File: rtl/fft_out_framer.sv
// fft_out_framer: two-bank (ping-pong) output frame buffer behind the radix-3
// FFT digit-reversal stage. One bank fills from di_en bursts while the other
// drains through a valid/ready port with sample index and end-of-frame flag.
// Optional feature: define FFT_OUT_FRAMER_OVF_CNT_EN to add o_ovf_cnt, a
// saturating 8-bit count of dropped input samples.
//
// Handshake: a sample transfers on a rising edge where o_do_en & i_do_ready;
// while o_do_en is high and i_do_ready is low every o_do_* output holds.
module fft_out_framer #(
  parameter int WIDTH = 18,
  parameter int DEPTH = 243,
  parameter int AW    = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] i_di_re,
  input  logic [WIDTH-1:0] i_di_im,
  input  logic             i_di_en,
  input  logic [2:0]       i_stages,
  output logic [WIDTH-1:0] o_do_re,
  output logic [WIDTH-1:0] o_do_im,
  output logic             o_do_en,
  input  logic             i_do_ready,
  output logic [AW-1:0]    o_do_idx,
  output logic             o_do_last,
  output logic             o_overflow,
`ifdef FFT_OUT_FRAMER_OVF_CNT_EN
  output logic [7:0]       o_ovf_cnt,
`endif
  output logic [1:0]       o_dbg_state
);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_LOAD = 2'd1, S_SEND = 2'd2} state_t;

  localparam logic [AW-1:0] IDX0 = '0;
  localparam logic [AW-1:0] IDX1 = AW'(1);

  // Frame length for a Stages code; zero marks a disabled code.
  function automatic logic [AW-1:0] f_len(input logic [2:0] s);
    case (s)
      3'd1:    f_len = AW'(3);
      3'd2:    f_len = AW'(9);
      3'd3:    f_len = AW'(27);
      3'd4:    f_len = AW'(81);
      3'd5:    f_len = AW'(243);
      default: f_len = '0;
    endcase
  endfunction

  logic [2*WIDTH-1:0] r_mem [2][DEPTH];
  logic [1:0]         r_full;
  logic [AW-1:0]      r_len [2];
  logic [AW-1:0]      r_wptr;
  logic               r_wb;
  logic               r_rb;
  logic               r_overflow;
  state_t             r_state;
  logic [2*WIDTH-1:0] r_rdata;
  logic [WIDTH-1:0]   r_do_re;
  logic [WIDTH-1:0]   r_do_im;
  logic               r_do_en;
  logic [AW-1:0]      r_do_idx;
`ifdef FFT_OUT_FRAMER_OVF_CNT_EN
  logic [7:0]         r_ovf_cnt;
`endif

  logic [AW-1:0] w_dec_len;
  logic [AW-1:0] w_cur_len;
  logic          w_frame_start;
  logic          w_ignore;
  logic          w_drop;
  logic          w_wr;
  logic          w_wlast;
  logic [1:0]    w_set;
  logic [1:0]    w_clr;
  logic [AW-1:0] w_rlen_m1;
  logic          w_rlast_xfer;
  logic [AW-1:0] w_pf_addr;

  // Writer decisions: the length is sampled from Stages only at frame start,
  // afterwards the latched bank length governs.
  assign w_frame_start = (r_wptr == IDX0);
  assign w_dec_len     = f_len(i_stages);
  assign w_cur_len     = w_frame_start ? w_dec_len : r_len[r_wb];
  assign w_ignore      = i_di_en & w_frame_start & (w_dec_len == IDX0);
  assign w_drop        = i_di_en & r_full[r_wb] & ~w_ignore;
  assign w_wr          = i_di_en & ~r_full[r_wb] & ~w_ignore;
  assign w_wlast       = w_wr & (r_wptr == (w_cur_len - IDX1));
  assign w_set[0]      = w_wlast & ~r_wb;
  assign w_set[1]      = w_wlast & r_wb;

  // Reader decisions: last sample of the bank leaves on this edge.
  assign w_rlen_m1     = r_len[r_rb] - IDX1;
  assign w_rlast_xfer  = (r_state == S_SEND) & r_do_en & i_do_ready & (r_do_idx == w_rlen_m1);
  assign w_clr[0]      = w_rlast_xfer & ~r_rb;
  assign w_clr[1]      = w_rlast_xfer & r_rb;
  assign w_pf_addr     = r_do_idx + AW'(2);

  // Sample storage; contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (w_wr) r_mem[r_wb][r_wptr] <= {i_di_re, i_di_im};
  end

  // Writer: pointer, bank select, latched lengths and drop tracking.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wptr     <= '0;
      r_wb       <= 1'b0;
      r_len[0]   <= '0;
      r_len[1]   <= '0;
      r_overflow <= 1'b0;
`ifdef FFT_OUT_FRAMER_OVF_CNT_EN
      r_ovf_cnt  <= '0;
`endif
    end else begin
      if (w_wr) begin
        if (w_frame_start) r_len[r_wb] <= w_dec_len;
        if (w_wlast) begin
          r_wptr <= '0;
          r_wb   <= ~r_wb;
        end else begin
          r_wptr <= r_wptr + IDX1;
        end
      end
      if (w_drop) begin
        r_overflow <= 1'b1;
`ifdef FFT_OUT_FRAMER_OVF_CNT_EN
        if (r_ovf_cnt != 8'hFF) r_ovf_cnt <= r_ovf_cnt + 8'd1;
`endif
      end
    end
  end

  // Bank full flags: writer sets and reader clears never target the same bank.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_full <= '0;
    else     r_full <= (r_full | w_set) & ~w_clr;
  end

  // Reader FSM with a one-entry prefetch register (r_rdata) ahead of do_*.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_rb     <= 1'b0;
      r_rdata  <= '0;
      r_do_re  <= '0;
      r_do_im  <= '0;
      r_do_en  <= 1'b0;
      r_do_idx <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (r_full[r_rb]) begin
            r_rdata <= r_mem[r_rb][IDX0];
            r_state <= S_LOAD;
          end
        end
        S_LOAD: begin
          r_do_re  <= r_rdata[2*WIDTH-1:WIDTH];
          r_do_im  <= r_rdata[WIDTH-1:0];
          r_do_en  <= 1'b1;
          r_do_idx <= '0;
          r_rdata  <= r_mem[r_rb][IDX1];
          r_state  <= S_SEND;
        end
        S_SEND: begin
          if (r_do_en & i_do_ready) begin
            if (r_do_idx == w_rlen_m1) begin
              r_do_en <= 1'b0;
              r_rb    <= ~r_rb;
              if (r_full[~r_rb]) begin
                r_rdata <= r_mem[~r_rb][IDX0];
                r_state <= S_LOAD;
              end else begin
                r_state <= S_IDLE;
              end
            end else begin
              r_do_re  <= r_rdata[2*WIDTH-1:WIDTH];
              r_do_im  <= r_rdata[WIDTH-1:0];
              r_do_idx <= r_do_idx + IDX1;
              if (w_pf_addr < AW'(DEPTH)) r_rdata <= r_mem[r_rb][w_pf_addr];
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign o_do_re     = r_do_re;
  assign o_do_im     = r_do_im;
  assign o_do_en     = r_do_en;
  assign o_do_idx    = r_do_idx;
  assign o_do_last   = r_do_en & (r_do_idx == w_rlen_m1);
  assign o_overflow  = r_overflow;
  assign o_dbg_state = r_state;
`ifdef FFT_OUT_FRAMER_OVF_CNT_EN
  assign o_ovf_cnt   = r_ovf_cnt;
`endif

endmodule

// File: tb/tb_fft_out_framer.sv
// Directed bench for fft_out_framer: one task per scenario, inline checks,
// expected output words queued as {last, idx, re, im}.
module tb_fft_out_framer;

  localparam int WIDTH = 18;
  localparam int AW    = 8;
  localparam int EW    = 1 + AW + 2 * WIDTH;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [WIDTH-1:0] i_di_re = '0;
  logic [WIDTH-1:0] i_di_im = '0;
  logic             i_di_en = 1'b0;
  logic [2:0]       i_stages = 3'd0;
  logic [WIDTH-1:0] o_do_re;
  logic [WIDTH-1:0] o_do_im;
  logic             o_do_en;
  logic             i_do_ready = 1'b1;
  logic [AW-1:0]    o_do_idx;
  logic             o_do_last;
  logic             o_overflow;
  logic [1:0]       o_dbg_state;
`ifdef FFT_OUT_FRAMER_OVF_CNT_EN
  logic [7:0]       o_ovf_cnt;
`endif

  int errors = 0;
  int checks = 0;
  logic [EW-1:0] exp_q[$];

  fft_out_framer #(.WIDTH(WIDTH), .DEPTH(243), .AW(AW)) dut (
    .clk(clk), .rst(rst),
    .i_di_re(i_di_re), .i_di_im(i_di_im), .i_di_en(i_di_en), .i_stages(i_stages),
    .o_do_re(o_do_re), .o_do_im(o_do_im), .o_do_en(o_do_en), .i_do_ready(i_do_ready),
    .o_do_idx(o_do_idx), .o_do_last(o_do_last), .o_overflow(o_overflow),
`ifdef FFT_OUT_FRAMER_OVF_CNT_EN
    .o_ovf_cnt(o_ovf_cnt),
`endif
    .o_dbg_state(o_dbg_state)
  );

  // Clock / reset
  always #5 clk = ~clk;

  task automatic apply_reset();
    rst = 1'b1;
    i_di_en = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  function automatic logic [WIDTH-1:0] mk_im(input int re);
    logic [WIDTH-1:0] v;
    v = WIDTH'(re + 1000);
    return v;
  endfunction

  function automatic logic [EW-1:0] pk(input int last, input int idx, input int re);
    logic [AW-1:0]    vi;
    logic [WIDTH-1:0] vr;
    vi = AW'(idx);
    vr = WIDTH'(re);
    return {last != 0, vi, vr, mk_im(re)};
  endfunction

  // Drive n consecutive samples re = base + i; leaves di_en low afterwards.
  task automatic drive_samples(input int n, input int base);
    for (int i = 0; i < n; i++) begin
      i_di_re = WIDTH'(base + i);
      i_di_im = mk_im(base + i);
      i_di_en = 1'b1;
      @(posedge clk);
      #1;
    end
    i_di_en = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #2;
    checks++;
    if ({o_do_en, o_do_last, o_overflow, o_do_idx, o_do_re, o_do_im} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got en=%b last=%b ovf=%b idx=%0d re=%0d im=%0d, want all 0",
               o_do_en, o_do_last, o_overflow, o_do_idx, o_do_re, o_do_im);
    end
    apply_reset();
    checks++;
    if (o_dbg_state !== 2'd0) begin
      errors++;
      $display("FAIL reset_state: got %0d want 0", o_dbg_state);
    end
  endtask

  // Stages=2: latency of 2 cycles, then 9 outputs on consecutive cycles.
  task automatic test_basic();
    logic [EW-1:0] e;
    apply_reset();
    i_stages = 3'd2;
    i_do_ready = 1'b1;
    drive_samples(9, 0);
    @(posedge clk); #1;
    checks++;
    if (o_do_en !== 1'b0) begin
      errors++;
      $display("FAIL basic_latency_early: do_en=%b want 0 one cycle after last input", o_do_en);
    end
    @(posedge clk); #1;
    for (int k = 0; k < 9; k++) begin
      e = pk(k == 8, k, k);
      checks++;
      if ({o_do_en, o_do_last, o_do_idx, o_do_re, o_do_im} !== {1'b1, e}) begin
        errors++;
        $display("FAIL basic_out k=%0d: got en=%b last=%b idx=%0d re=%0d, want en=1 last=%0d idx=%0d re=%0d",
                 k, o_do_en, o_do_last, o_do_idx, o_do_re, k == 8, k, k);
      end
      @(posedge clk); #1;
    end
    checks++;
    if (o_do_en !== 1'b0) begin
      errors++;
      $display("FAIL basic_end: do_en=%b want 0 after frame", o_do_en);
    end
  endtask

  // Stages=5: two back-to-back 243-sample frames, at most one gap cycle.
  task automatic test_back_to_back();
    int got, cyc, gap;
    bit started;
    logic [EW-1:0] e;
    apply_reset();
    i_stages = 3'd5;
    i_do_ready = 1'b1;
    exp_q.delete();
    for (int i = 0; i < 486; i++) exp_q.push_back(pk((i % 243) == 242, i % 243, i));
    got = 0; cyc = 0; gap = 0; started = 0;
    fork
      drive_samples(486, 0);
      begin
        while (got < 486 && cyc < 2000) begin
          @(posedge clk); #1;
          cyc++;
          if (o_do_en) begin
            e = exp_q.pop_front();
            checks++;
            if ({o_do_last, o_do_idx, o_do_re, o_do_im} !== e) begin
              errors++;
              $display("FAIL b2b_sample %0d: got %h want %h", got,
                       {o_do_last, o_do_idx, o_do_re, o_do_im}, e);
            end
            got++;
            started = 1;
          end else if (started) begin
            gap++;
          end
        end
      end
    join
    checks++;
    if (got != 486) begin
      errors++;
      $display("FAIL b2b_count: got %0d outputs want 486", got);
    end
    checks++;
    if (gap > 1) begin
      errors++;
      $display("FAIL b2b_gap: got %0d gap cycles want at most 1", gap);
    end
    checks++;
    if (o_overflow !== 1'b0) begin
      errors++;
      $display("FAIL b2b_overflow: got %b want 0", o_overflow);
    end
  endtask

  // Stages=1 with do_ready toggling every cycle; outputs hold while stalled.
  task automatic test_ready_toggle();
    int got, cyc;
    apply_reset();
    i_stages = 3'd1;
    i_do_ready = 1'b0;
    exp_q.delete();
    for (int i = 0; i < 3; i++) exp_q.push_back(pk(i == 2, i, 10 + i));
    drive_samples(3, 10);
    got = 0; cyc = 0;
    while (got < 3 && cyc < 50) begin
      @(posedge clk); #1;
      cyc++;
      if (o_do_en) begin
        checks++;
        if ({o_do_last, o_do_idx, o_do_re, o_do_im} !== exp_q[0]) begin
          errors++;
          $display("FAIL toggle_sample %0d ready=%b: got %h want %h", got, i_do_ready,
                   {o_do_last, o_do_idx, o_do_re, o_do_im}, exp_q[0]);
        end
      end
      i_do_ready = ~i_do_ready;
      if (i_do_ready && o_do_en) begin
        void'(exp_q.pop_front());
        got++;
      end
    end
    @(posedge clk); #1;
    checks++;
    if (got != 3 || o_do_en !== 1'b0) begin
      errors++;
      $display("FAIL toggle_end: got %0d outputs en=%b want 3 outputs en=0", got, o_do_en);
    end
    i_do_ready = 1'b1;
  endtask

  // Stages=3, consumer stalled: two frames buffered, third frame dropped.
  task automatic test_overflow();
    int got, cyc;
    logic [EW-1:0] e;
    apply_reset();
    i_stages = 3'd3;
    i_do_ready = 1'b0;
    drive_samples(54, 0);
    checks++;
    if (o_overflow !== 1'b0) begin
      errors++;
      $display("FAIL ovf_before_drop: got %b want 0", o_overflow);
    end
    drive_samples(27, 54);
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (o_overflow !== 1'b1) begin
      errors++;
      $display("FAIL ovf_flag: got %b want 1", o_overflow);
    end
`ifdef FFT_OUT_FRAMER_OVF_CNT_EN
    checks++;
    if (o_ovf_cnt !== 8'd27) begin
      errors++;
      $display("FAIL ovf_cnt: got %0d want 27", o_ovf_cnt);
    end
`endif
    checks++;
    if ({o_do_en, o_do_idx, o_do_re} !== {1'b1, 8'd0, 18'd0}) begin
      errors++;
      $display("FAIL ovf_hold: got en=%b idx=%0d re=%0d want en=1 idx=0 re=0", o_do_en, o_do_idx, o_do_re);
    end
    exp_q.delete();
    for (int i = 0; i < 54; i++) exp_q.push_back(pk((i % 27) == 26, i % 27, i));
    i_do_ready = 1'b1;
    got = 0; cyc = 0;
    while (cyc < 80) begin
      if (o_do_en) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL ovf_extra: unexpected output idx=%0d re=%0d", o_do_idx, o_do_re);
        end else begin
          e = exp_q.pop_front();
          if ({o_do_last, o_do_idx, o_do_re, o_do_im} !== e) begin
            errors++;
            $display("FAIL ovf_sample %0d: got %h want %h", got, {o_do_last, o_do_idx, o_do_re, o_do_im}, e);
          end
        end
        got++;
      end
      @(posedge clk); #1;
      cyc++;
    end
    checks++;
    if (got != 54 || o_overflow !== 1'b1) begin
      errors++;
      $display("FAIL ovf_drain: got %0d outputs ovf=%b want 54 outputs ovf=1", got, o_overflow);
    end
  endtask

  // Stages 4 -> 2 mid-frame: first frame stays 81 long, next frame is 9.
  task automatic test_stage_change();
    int got, cyc;
    logic [EW-1:0] e;
    apply_reset();
    i_stages = 3'd4;
    i_do_ready = 1'b1;
    exp_q.delete();
    for (int i = 0; i < 81; i++) exp_q.push_back(pk(i == 80, i, i));
    for (int i = 0; i < 9; i++) exp_q.push_back(pk(i == 8, i, 81 + i));
    got = 0; cyc = 0;
    fork
      begin
        drive_samples(10, 0);
        i_stages = 3'd2;
        drive_samples(80, 10);
      end
      begin
        while (got < 90 && cyc < 400) begin
          @(posedge clk); #1;
          cyc++;
          if (o_do_en) begin
            e = exp_q.pop_front();
            checks++;
            if ({o_do_last, o_do_idx, o_do_re, o_do_im} !== e) begin
              errors++;
              $display("FAIL stage_sample %0d: got %h want %h", got, {o_do_last, o_do_idx, o_do_re, o_do_im}, e);
            end
            got++;
          end
        end
      end
    join
    checks++;
    if (got != 90) begin
      errors++;
      $display("FAIL stage_count: got %0d outputs want 90", got);
    end
  endtask

  // Reset during a partial frame discards it; the next frame starts at idx 0.
  task automatic test_reset_mid_frame();
    int got, cyc;
    logic [EW-1:0] e;
    apply_reset();
    i_stages = 3'd2;
    i_do_ready = 1'b1;
    drive_samples(5, 100);
    repeat (4) @(posedge clk);
    #1;
    checks++;
    if (o_do_en !== 1'b0) begin
      errors++;
      $display("FAIL mid_partial: do_en=%b want 0 for partial frame", o_do_en);
    end
    rst = 1'b1;
    @(posedge clk); #1;
    checks++;
    if ({o_do_en, o_do_last, o_overflow, o_do_idx, o_do_re, o_do_im} !== '0) begin
      errors++;
      $display("FAIL mid_reset_outputs: got en=%b idx=%0d re=%0d want all 0", o_do_en, o_do_idx, o_do_re);
    end
    rst = 1'b0;
    exp_q.delete();
    for (int i = 0; i < 9; i++) exp_q.push_back(pk(i == 8, i, 200 + i));
    got = 0; cyc = 0;
    fork
      drive_samples(9, 200);
      begin
        while (got < 9 && cyc < 60) begin
          @(posedge clk); #1;
          cyc++;
          if (o_do_en) begin
            e = exp_q.pop_front();
            checks++;
            if ({o_do_last, o_do_idx, o_do_re, o_do_im} !== e) begin
              errors++;
              $display("FAIL mid_sample %0d: got %h want %h", got, {o_do_last, o_do_idx, o_do_re, o_do_im}, e);
            end
            got++;
          end
        end
      end
    join
    checks++;
    if (got != 9) begin
      errors++;
      $display("FAIL mid_count: got %0d outputs want 9", got);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_ready_toggle();
    test_overflow();
    test_stage_change();
    test_reset_mid_frame();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fft_out_framer.md
# fft_out_framer

Ping-pong frame buffer at the output of the radix-3 FFT digit-reversal reorder stage. Collects one reordered frame of N = 3^Stages complex samples (3..243) from the reorder output, then streams it downstream with a valid/ready handshake, sample index and end-of-frame flag. The writer fills one bank while the reader drains the other. This decouples the FFT's continuous `di_en` bursts from a back-pressured consumer such as the PUSCH demapper.

## Interface
- `WIDTH`, 18, bit width of each real/imag component
- `DEPTH`, 243, samples per bank (max frame, 3^5)
- `AW`, 8, index/address width (ceil log2 DEPTH)

- `clk` in 1: clock, rising edge
- `rst` in 1: asynchronous, active-high reset
- `di_re` in WIDTH: input real, two's complement
- `di_im` in WIDTH: input imag
- `di_en` in 1: input sample valid, one sample per cycle, no back-pressure
- `Stages` in 3: frame size select, N = 3^Stages for 1..5; 0, 6, 7 = disabled
- `do_re` out WIDTH: output real
- `do_im` out WIDTH: output imag
- `do_en` out 1: output valid
- `do_ready` in 1: downstream ready
- `do_idx` out AW: index of current output sample within frame, 0..N-1
- `do_last` out 1: high with the sample at index N-1
- `overflow` out 1: sticky, set when an input sample is dropped

## Operation
- Two banks, B0/B1, each DEPTH x 2·WIDTH. Each bank has a `full` flag and a latched length `len`.
- Writer:
  - Write pointer `wptr` and current bank `wb`. On the first `di_en` into an empty bank, Stages is decoded to N and latched as that bank's `len`.
  - Each `di_en` writes to `wb[wptr]` and increments `wptr`.
  - When `wptr` = len-1 is written, `full[wb]` is set, `wptr` goes to 0 and `wb` toggles.
  - If `full[wb]` is set when `di_en` arrives, the sample is dropped and `overflow` is set. Dropping continues until that bank empties, then the next `di_en` starts a new frame.
- Stages disabled (0, 6, 7) at frame start: `di_en` is ignored, nothing is written, `overflow` is unchanged.
- Stages changes mid-frame are ignored, because the latched `len` governs.
- Reader FSM:
  - IDLE: wait for `full[rb]`, then issue RAM read of index 0 and go to LOAD.
  - LOAD: register the RAM output into `do_*`, set `do_en`, `do_idx` = 0, and go to SEND.
  - SEND: on `do_en & do_ready`, advance. If `do_idx` = len-1, clear `full[rb]`, toggle `rb` and go to IDLE, or go straight to LOAD if the other bank is already full. Otherwise present the next sample.
  - In SEND, a prefetch register keeps throughput at 1 sample/cycle while `do_ready` stays high.
- Output is stable while `do_en & !do_ready`: all `do_*` hold.
- `do_last` = `do_en` & (`do_idx` == len-1).
- Simultaneous writer-sets-full and reader-clears-full on different banks are independent. The same bank cannot be both filled and drained, since the writer skips full banks.
- Reset values: `do_re`/`do_im`/`do_idx` = 0, `do_en`/`do_last`/`overflow` = 0; both banks empty; `wb` = `rb` = B0; `wptr` = 0; FSM = IDLE. RAM contents are not reset.
- Reset mid-frame discards both banks and any partial frame. The first `di_en` after release starts a new frame at index 0.

## Timing
- Last input sample written at edge t → `full` visible at t+1 → RAM read at t+1 → `do_en` = 1 with index 0 after edge t+2. First-sample latency is 2 cycles.
- With `do_ready` held high, N samples are output on N consecutive cycles.
- Between back-to-back banks: 1-cycle `do_en` gap (LOAD) at most.
- `overflow` sets on the edge that drops the sample and stays set until `rst`.

## Configuration
- `FFT_OUT_FRAMER_OVF_CNT_EN` defined: adds output `ovf_cnt` [7:0], a saturating count of dropped samples (stops at 255), reset to 0.
- Not defined: the port and counter are absent. Only the sticky `overflow` flag is provided.

## Test plan
- Stages=2, 9 samples re=0..8, `do_ready`=1 → `do_en` high 2 cycles after the 9th input; `do_re` 0..8 on 9 consecutive cycles, `do_idx` 0..8, `do_last` only at idx 8.
- Stages=5, two back-to-back 243-sample frames, `do_ready`=1 → 486 outputs in order with at most 1 gap cycle between frames; `overflow`=0.
- Stages=1, `do_ready` toggling 1/0 every cycle → 3 outputs, each held unchanged while `do_ready`=0; `do_last` on idx 2.
- Stages=3, `do_ready`=0, three 27-sample frames → first two buffered, all 27 of the third dropped; `overflow`=1 (`ovf_cnt`=27 with macro). Releasing `do_ready` yields exactly 54 samples.
- Stages=4, Stages changed to 2 after 10 samples → frame still completes at 81 samples with `len`=81; the next frame is 9 samples.
- `rst` asserted after 5 of 9 samples, then a full 9-sample frame → no output for the partial frame; the new frame is output with idx 0..8; all outputs are 0 during reset.
